clkgate_seq: RTL and testbench
==============================

Name: clkgate_seq

Overview:
- Sequencer that owns NUM_DOM integrated clock-gate cells (ICG with CK/E/SE/GCK). It drives each cell's E and the shared SE.
- Domains request their clock. The block turns a clock on only after a settle window, and turns it off after a programmable idle time.
- Only one domain may be waking at a time (inrush limiting). A round-robin arbiter shares that single wake slot between requesters.
- Sits between the domain controllers and the ICG cells at the top of the clock tree.

Parameters:
- NUM_DOM, 4, number of gated domains (2..8)
- WAKE_CYCLES, 2, cycles between E rising and RDY rising (>=1)
- IDLE_CYCLES, 8, consecutive quiet cycles before E falls (>=1)
- CNT_W, 4, counter width; must hold max(WAKE_CYCLES, IDLE_CYCLES)

Ports:
- CK  in  1  clock (ungated source clock)
- RN  in  1  reset, asynchronous, active-low
- TEST_SE  in  1  scan/test enable
- REQ  in  NUM_DOM  per-domain clock request, level
- BUSY  in  NUM_DOM  per-domain activity flag; holds the clock on while REQ is low
- E  out  NUM_DOM  to ICG E pins, registered
- SE  out  1  to all ICG SE pins
- RDY  out  NUM_DOM  per-domain "gated clock stable"

Behaviour:
- Clock and reset are fixed: one clock CK; reset RN is asynchronous and active-low.
- Reset (RN=0, asynchronous): every FSM goes to OFF, E=0, RDY=0, counters=0, arbiter pointer=0. SE still follows TEST_SE.
- Reset mid-operation: same result, immediately, from any state.
- SE = TEST_SE, combinational pass-through. The FSMs and counters keep running unaffected by TEST_SE.
- Per-domain FSM states are OFF, WAKE, ON and IDLE_WAIT. Outputs by state:
  - OFF: E=0, RDY=0.
  - WAKE: E=1, RDY=0.
  - ON: E=1, RDY=1.
  - IDLE_WAIT: E=1, RDY=1.
- Arbitration: a domain in OFF with REQ=1 is pending.
  - When no domain is in WAKE, exactly one pending domain is granted per cycle.
  - The search is round-robin, starting at the pointer. After a grant the pointer = granted index + 1 (mod NUM_DOM).
  - With no grant, the pointer holds.
- Transitions:
  - OFF -> WAKE on grant. E=1 from that edge; counter loads WAKE_CYCLES-1.
  - WAKE: the counter decrements each cycle. At 0 the FSM goes to ON and RDY=1.
  - REQ dropping during WAKE does not abort it. The FSM completes WAKE and then evaluates ON rules.
  - ON -> IDLE_WAIT when REQ=0 and BUSY=0 are sampled; counter loads IDLE_CYCLES-1.
  - IDLE_WAIT -> ON when REQ=1 or BUSY=1 is sampled. This has priority over expiry, including at count 0.
  - IDLE_WAIT -> OFF when the count is 0 and REQ=BUSY=0. E and RDY fall together.
- Latency:
  - REQ sampled at edge n with the slot free: E=1 after edge n+1, RDY=1 after edge n+1+WAKE_CYCLES.
  - Quiet from edge k in ON: E=0 after edge k+IDLE_CYCLES.
- Simultaneous requests from several OFF domains are served one at a time, each after the previous one leaves WAKE.
- A domain in OFF with REQ=0 and BUSY=1 stays OFF; BUSY alone never wakes a domain.

Decomposition:
- Package clkgate_seq_pkg holds:
  - the state enum (OFF, WAKE, ON, IDLE_WAIT), 2 bits;
  - the WAKE_CYCLES/IDLE_CYCLES defaults;
  - the CNT_W sizing function.
- Sub-module clkgate_dom_fsm, instantiated NUM_DOM times:
  - inputs: grant, REQ, BUSY;
  - outputs: E, RDY, in_wake.
- The top level holds the round-robin arbiter and the SE pass-through.

Test Plan:
- Reset/test: RN=0 with REQ=4'hF and TEST_SE=1 -> E=0, RDY=0, SE=1. Then RN=1 and TEST_SE=0 -> SE=0 and the wakes begin.
- Single wake/sleep: REQ[0]=1 at edge 10 -> E[0]=1 after edge 11, RDY[0]=1 after edge 13. REQ[0]=0 at edge 20 -> E[0]=0 after edge 28.
- Contention: REQ=4'hF at edge 5 -> wakes granted in order 0,1,2,3, one every 2 cycles; E rises after edges 6, 8, 10, 12. Never two domains in WAKE together.
- Round-robin fairness: pointer at 2 with REQ=4'b1011 pending -> domain 3 is granted first, then 0, then 1.
- Idle abort: REQ[1] drops and BUSY[1]=1 is raised at IDLE_WAIT count 0 -> E[1] stays 1 and the FSM returns to ON. A later quiet period gates after the full 8 cycles.
- Async reset mid-WAKE: RN low between edges -> E and RDY go 0 immediately, without waiting for CK. After release, a fresh REQ repeats the full 2-cycle wake.

Source files
------------

// File: rtl/clkgate_seq_pkg.sv
// rtl/clkgate_seq_pkg.sv - shared types, defaults and sizing helper for the clock-gate sequencer
package clkgate_seq_pkg;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_WAKE      = 2'd1,
    ST_ON        = 2'd2,
    ST_IDLE_WAIT = 2'd3
  } dom_state_e;

  localparam int WAKE_CYCLES_DEF = 2;
  localparam int IDLE_CYCLES_DEF = 8;

  // Width needed to hold the larger of the two windows.
  function automatic int cnt_width(input int wake_cycles, input int idle_cycles);
    int m;
    m = (wake_cycles > idle_cycles) ? wake_cycles : idle_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clkgate_dom_fsm.sv
// rtl/clkgate_dom_fsm.sv - per-domain OFF/WAKE/ON/IDLE_WAIT sequencer driving one ICG enable
module clkgate_dom_fsm
  import clkgate_seq_pkg::*;
#(
  parameter int WAKE_CYCLES = WAKE_CYCLES_DEF,
  parameter int IDLE_CYCLES = IDLE_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic ck,
  input  logic rn,
  input  logic grant,
  input  logic req,
  input  logic busy,
  output logic e,
  output logic rdy,
  output logic in_wake
);

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);

  dom_state_e       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge ck or negedge rn) begin
    if (!rn) begin
      state <= ST_OFF;
      cnt   <= '0;
      e     <= 1'b0;
      rdy   <= 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          if (grant) begin
            state <= ST_WAKE;
            cnt   <= WAKE_LOAD;
            e     <= 1'b1;
          end
        end
        // A dropped request does not abort the wake; ON decides afterwards.
        ST_WAKE: begin
          if (cnt == '0) begin
            state <= ST_ON;
            rdy   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_ON: begin
          if (!req && !busy) begin
            state <= ST_IDLE_WAIT;
            cnt   <= IDLE_LOAD;
          end
        end
        ST_IDLE_WAIT: begin
          if (req || busy) begin
            state <= ST_ON;
          end else if (cnt == '0) begin
            state <= ST_OFF;
            e     <= 1'b0;
            rdy   <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_OFF;
          cnt   <= '0;
          e     <= 1'b0;
          rdy   <= 1'b0;
        end
      endcase
    end
  end

  // The wake slot is released on the final WAKE cycle so the next domain
  // enters WAKE on the same edge this one leaves it.
  assign in_wake = (state == ST_WAKE) && (cnt != '0);

endmodule

// File: rtl/clkgate_seq.sv
// rtl/clkgate_seq.sv - ICG enable sequencer with round-robin single-slot wake arbitration
module clkgate_seq
  import clkgate_seq_pkg::*;
#(
  parameter int NUM_DOM     = 4,
  parameter int WAKE_CYCLES = WAKE_CYCLES_DEF,
  parameter int IDLE_CYCLES = IDLE_CYCLES_DEF,
  parameter int CNT_W       = cnt_width(WAKE_CYCLES, IDLE_CYCLES)
) (
  input  logic               CK,
  input  logic               RN,
  input  logic               TEST_SE,
  input  logic [NUM_DOM-1:0] REQ,
  input  logic [NUM_DOM-1:0] BUSY,
  output logic [NUM_DOM-1:0] E,
  output logic               SE,
  output logic [NUM_DOM-1:0] RDY
);

  localparam int PTR_W = $clog2(NUM_DOM);

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   cand;
  logic               gnt_vld;
  logic [NUM_DOM-1:0] gnt;
  logic [NUM_DOM-1:0] pend;
  logic [NUM_DOM-1:0] in_wake;

  assign SE = TEST_SE;

  // E is low exactly in OFF, so REQ & ~E marks the pending domains.
  assign pend = REQ & ~E;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    if (!(|in_wake)) begin
      for (int i = 0; i < NUM_DOM; i++) begin
        cand = PTR_W'((int'(ptr) + i) % NUM_DOM);
        if (!gnt_vld && pend[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= (gnt_idx == PTR_W'(NUM_DOM - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_DOM; g++) begin : g_dom
    clkgate_dom_fsm #(
      .WAKE_CYCLES (WAKE_CYCLES),
      .IDLE_CYCLES (IDLE_CYCLES),
      .CNT_W       (CNT_W)
    ) u_fsm (
      .ck      (CK),
      .rn      (RN),
      .grant   (gnt[g]),
      .req     (REQ[g]),
      .busy    (BUSY[g]),
      .e       (E[g]),
      .rdy     (RDY[g]),
      .in_wake (in_wake[g])
    );
  end

endmodule

// File: tb/tb_clkgate_seq.sv
// tb/tb_clkgate_seq.sv - directed self-checking bench for clkgate_seq
module tb_clkgate_seq;

  logic       CK = 1'b0;
  logic       RN;
  logic       TEST_SE;
  logic [3:0] REQ;
  logic [3:0] BUSY;
  logic [3:0] E;
  logic       SE;
  logic [3:0] RDY;

  int n_cmp = 0;
  int n_mis = 0;

  clkgate_seq #(
    .NUM_DOM     (4),
    .WAKE_CYCLES (2),
    .IDLE_CYCLES (8),
    .CNT_W       (4)
  ) dut (
    .CK      (CK),
    .RN      (RN),
    .TEST_SE (TEST_SE),
    .REQ     (REQ),
    .BUSY    (BUSY),
    .E       (E),
    .SE      (SE),
    .RDY     (RDY)
  );

  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CK);
      #1;
    end
  endtask

  // Expected E/RDY after each edge when all four request together from pointer 0.
  logic [3:0] cont_e   [9] = '{4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hF, 4'hF, 4'hF};
  logic [3:0] cont_rdy [9] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hF};

  initial begin
    RN      = 1'b0;
    TEST_SE = 1'b1;
    REQ     = 4'hF;
    BUSY    = 4'h0;
    tick(2);
    chk("rst_e", E, 4'h0);
    chk("rst_rdy", RDY, 4'h0);
    chk("rst_se", SE, 1'b1);

    RN      = 1'b1;
    TEST_SE = 1'b0;
    #1;
    chk("se_low", SE, 1'b0);

    for (int c = 0; c < 9; c++) begin
      tick(1);
      chk($sformatf("cont_e%0d", c), E, cont_e[c]);
      chk($sformatf("cont_rdy%0d", c), RDY, cont_rdy[c]);
      chk($sformatf("one_wake%0d", c), $countones(E & ~RDY) <= 1, 1);
    end

    // All quiet: E falls IDLE_CYCLES edges after quiet is first sampled.
    REQ = 4'h0;
    tick(8);
    chk("idle_hold", E, 4'hF);
    tick(1);
    chk("idle_off", E, 4'h0);

    REQ = 4'h1;
    tick(1);
    chk("w0_e", E, 4'h1);
    chk("w0_rdy_a", RDY, 4'h0);
    tick(1);
    chk("w0_rdy_b", RDY, 4'h0);
    tick(1);
    chk("w0_rdy_c", RDY, 4'h1);
    REQ = 4'h0;
    tick(8);
    chk("s0_hold", E, 4'h1);
    tick(1);
    chk("s0_off", E, 4'h0);

    // Wake/sleep domain 1 alone to move the pointer to 2.
    REQ = 4'h2;
    tick(3);
    chk("w1_rdy", RDY, 4'h2);
    REQ = 4'h0;
    tick(9);
    chk("s1_off", E, 4'h0);

    REQ = 4'hB;
    tick(1);
    chk("rr_first", E, 4'h8);
    tick(2);
    chk("rr_second", E, 4'h9);
    tick(2);
    chk("rr_third", E, 4'hB);
    chk("rr_rdy_a", RDY, 4'h9);
    tick(2);
    chk("rr_rdy_b", RDY, 4'hB);

    // Idle abort: BUSY[1] seen exactly at IDLE_WAIT count 0.
    REQ = 4'h0;
    tick(8);
    chk("ab_cnt0", E, 4'hB);
    BUSY = 4'h2;
    tick(1);
    chk("ab_e", E, 4'h2);
    chk("ab_rdy", RDY, 4'h2);
    BUSY = 4'h0;
    tick(8);
    chk("ab_full_hold", E, 4'h2);
    tick(1);
    chk("ab_full_off", E, 4'h0);

    BUSY = 4'h4;
    tick(3);
    chk("busy_only", E, 4'h0);
    BUSY = 4'h0;

    // Asynchronous reset in the middle of a wake.
    TEST_SE = 1'b1;
    REQ     = 4'h4;
    tick(1);
    chk("ar_wake", E, 4'h4);
    chk("ar_se", SE, 1'b1);
    #3;
    RN = 1'b0;
    #1;
    chk("ar_e", E, 4'h0);
    chk("ar_rdy", RDY, 4'h0);
    #1;
    RN = 1'b1;
    tick(1);
    chk("ar2_e", E, 4'h4);
    chk("ar2_rdy_a", RDY, 4'h0);
    tick(1);
    chk("ar2_rdy_b", RDY, 4'h0);
    tick(1);
    chk("ar2_rdy_c", RDY, 4'h4);

    REQ     = 4'h0;
    TEST_SE = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
